dot_product_mac: RTL and testbench

- Streaming multiply-accumulate stage that sits directly downstream of the 8x8 Wallace-tree `multiplier` and instantiates it.
- Accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and registers each pair in front of the combinational multiplier.
- Accumulates the 16-bit products over groups of LEN pairs.
- Emits one dot-product result per group over a valid/ready handshake, with a per-group overflow flag.

---
 rtl/dot_product_mac_if.sv | 27 ++
 rtl/dot_product_mac.sv | 147 ++++++++++++++
 tb/tb_dot_product_mac.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_mac_if.sv
// Streaming handshake bundle for dot_product_mac.
//   in_valid/in_ready/in_a/in_b      : operand-pair stream into the MAC
//   out_valid/out_ready/out_sum/out_ovf : per-group result stream out of the MAC
// Modports: master = producer/consumer side (testbench or upstream logic),
//           slave  = the MAC itself.
interface dot_product_mac_if #(
  parameter int unsigned ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/dot_product_mac.sv
// multiplier      : 8x8 unsigned Wallace-tree multiplier (combinational).
//   a, b : 8-bit operands      p : 16-bit product
// dot_product_mac : streaming MAC; registers each operand pair, multiplies it,
//   and accumulates LEN products into one ACC_W-bit result with an overflow flag.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   clear : synchronous flush of the partial group
//   bus   : dot_product_mac_if slave (operand stream in, result stream out)
module multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  function automatic logic [15:0] csa_s(input logic [15:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_c(input logic [15:0] x, y, z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] pp [8];

  // Shifted partial-product rows
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = 16'(a & {8{b[i]}}) << i;
    end
  end

  // Carry-save reduction 8 -> 6 -> 4 -> 3 -> 2 rows, then one final adder
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  assign s0 = csa_s(pp[0], pp[1], pp[2]);
  assign c0 = csa_c(pp[0], pp[1], pp[2]);
  assign s1 = csa_s(pp[3], pp[4], pp[5]);
  assign c1 = csa_c(pp[3], pp[4], pp[5]);
  assign s2 = csa_s(s0, c0, s1);
  assign c2 = csa_c(s0, c0, s1);
  assign s3 = csa_s(c1, pp[6], pp[7]);
  assign c3 = csa_c(c1, pp[6], pp[7]);
  assign s4 = csa_s(s2, c2, s3);
  assign c4 = csa_c(s2, c2, s3);
  assign s5 = csa_s(s4, c4, c3);
  assign c5 = csa_c(s4, c4, c3);
  assign p  = s5 + c5;
endmodule

module dot_product_mac #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned ACC_W = 20
) (
  input logic              clk,
  input logic              rst,
  input logic              clear,
  dot_product_mac_if.slave bus
);
  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic             s1_valid;
  logic [7:0]       s1_a;
  logic [7:0]       s1_b;
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;
  logic             out_valid;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  logic             stall_c;
  logic             accept_c;
  logic             fire_c;
  logic             done_c;
  logic [ACC_W:0]   sum_c;

  multiplier u_mult (
    .a(s1_a),
    .b(s1_b),
    .p(prod)
  );

  // Only the group-closing pair can be blocked, and only by an unretired result
  assign stall_c  = out_valid && !bus.out_ready && s1_valid && (cnt == LAST);
  assign accept_c = bus.in_valid && !stall_c && !clear;
  assign fire_c   = s1_valid && !stall_c && !clear;
  assign done_c   = fire_c && (cnt == LAST);
  // Extra top bit captures the carry out of the accumulator width
  assign sum_c    = {1'b0, acc} + (ACC_W + 1)'(prod);

  // Operand register, accumulator and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (clear) begin
        s1_valid <= 1'b0;
        acc      <= '0;
        cnt      <= '0;
        ovf_acc  <= 1'b0;
      end else begin
        if (accept_c) begin
          s1_a     <= bus.in_a;
          s1_b     <= bus.in_b;
          s1_valid <= 1'b1;
        end else if (!stall_c) begin
          s1_valid <= 1'b0;
        end

        if (fire_c) begin
          if (done_c) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
          end else begin
            acc     <= sum_c[ACC_W-1:0];
            ovf_acc <= ovf_acc | sum_c[ACC_W];
            cnt     <= cnt + CNT_W'(1);
          end
        end
      end

      // A completing group reloads the result even on the retiring edge
      if (done_c) begin
        out_valid <= 1'b1;
        out_sum   <= sum_c[ACC_W-1:0];
        out_ovf   <= ovf_acc | sum_c[ACC_W];
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !stall_c && !clear;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_ovf   = out_ovf;
endmodule

// File: tb/tb_dot_product_mac.sv
// Directed bench for dot_product_mac: four instances (LEN=8/20b, LEN=2/20b,
// LEN=4/20b, LEN=2/16b) share clk/rst/clear/operands, each with its own
// valid/ready, then a random stream on the 16-bit instance against a model.
module tb_dot_product_mac;
  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        vld  [4];
  logic        ordy [4];
  logic        rdy  [4];
  logic        ov   [4];
  logic [31:0] os   [4];
  logic        of   [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dot_product_mac_if #(.ACC_W(20)) bus0 ();
  dot_product_mac_if #(.ACC_W(20)) bus1 ();
  dot_product_mac_if #(.ACC_W(20)) bus2 ();
  dot_product_mac_if #(.ACC_W(16)) bus3 ();

  dot_product_mac #(.LEN(8), .ACC_W(20)) u_len8 (.clk(clk), .rst(rst), .clear(clear), .bus(bus0));
  dot_product_mac #(.LEN(2), .ACC_W(20)) u_len2 (.clk(clk), .rst(rst), .clear(clear), .bus(bus1));
  dot_product_mac #(.LEN(4), .ACC_W(20)) u_len4 (.clk(clk), .rst(rst), .clear(clear), .bus(bus2));
  dot_product_mac #(.LEN(2), .ACC_W(16)) u_w16  (.clk(clk), .rst(rst), .clear(clear), .bus(bus3));

  assign bus0.in_valid = vld[0];  assign bus0.out_ready = ordy[0];
  assign bus0.in_a = a;           assign bus0.in_b = b;
  assign rdy[0] = bus0.in_ready;  assign ov[0] = bus0.out_valid;
  assign os[0] = 32'(bus0.out_sum); assign of[0] = bus0.out_ovf;

  assign bus1.in_valid = vld[1];  assign bus1.out_ready = ordy[1];
  assign bus1.in_a = a;           assign bus1.in_b = b;
  assign rdy[1] = bus1.in_ready;  assign ov[1] = bus1.out_valid;
  assign os[1] = 32'(bus1.out_sum); assign of[1] = bus1.out_ovf;

  assign bus2.in_valid = vld[2];  assign bus2.out_ready = ordy[2];
  assign bus2.in_a = a;           assign bus2.in_b = b;
  assign rdy[2] = bus2.in_ready;  assign ov[2] = bus2.out_valid;
  assign os[2] = 32'(bus2.out_sum); assign of[2] = bus2.out_ovf;

  assign bus3.in_valid = vld[3];  assign bus3.out_ready = ordy[3];
  assign bus3.in_a = a;           assign bus3.in_b = b;
  assign rdy[3] = bus3.in_ready;  assign ov[3] = bus3.out_valid;
  assign os[3] = 32'(bus3.out_sum); assign of[3] = bus3.out_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Four back-to-back pairs into a LEN=2 instance with out_ready=1; results
  // appear after the 3rd and 5th edges as single-cycle pulses.
  task automatic len2_stream(input int k, input logic [31:0] pa, input logic [31:0] pb,
                             input logic [31:0] s0, input logic o0,
                             input logic [31:0] s1, input logic o1, input string tag);
    ordy[k] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("%s_valid%0d", tag, i), 32'(ov[k]), 32'((i == 3) || (i == 5)));
      if (i == 3) begin
        check({tag, "_sum0"}, os[k], s0);
        check({tag, "_ovf0"}, 32'(of[k]), 32'(o0));
      end
      if (i == 5) begin
        check({tag, "_sum1"}, os[k], s1);
        check({tag, "_ovf1"}, 32'(of[k]), 32'(o1));
      end
      if (i < 4) begin
        a = pa[8*i +: 8];
        b = pb[8*i +: 8];
        vld[k] = 1'b1;
        #1;
        check($sformatf("%s_ready%0d", tag, i), 32'(rdy[k]), 32'd1);
      end else begin
        vld[k] = 1'b0;
      end
    end
  endtask

  initial begin
    int unsigned macc;
    int unsigned mcnt;
    int unsigned p;
    int unsigned s;
    logic        movf;
    logic        carry;
    logic [16:0] q[$];
    logic [16:0] e;
    int          n_acc;
    int          cyc;
    int          dcnt;
    int          t;

    rst = 1'b1; clear = 1'b0; a = '0; b = '0;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0;
      ordy[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_sum%0d", k), os[k], 32'd0);
      check($sformatf("rst_ovf%0d", k), 32'(of[k]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);

    // LEN=8: eight (255,255); result visible on the second edge counting the 8th accept
    ordy[0] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i >= 1) check($sformatf("l8_valid%0d", i), 32'(ov[0]), 32'(i == 9));
      if (i == 9) begin
        check("l8_sum", os[0], 32'd520200);
        check("l8_ovf", 32'(of[0]), 32'd0);
      end
      if (i < 8) begin
        a = 8'd255; b = 8'd255; vld[0] = 1'b1;
        #1;
        check($sformatf("l8_ready%0d", i), 32'(rdy[0]), 32'd1);
      end else begin
        vld[0] = 1'b0;
      end
    end

    // LEN=2 back-to-back: 95128 then 32250
    len2_stream(1, {8'd174, 8'd12, 8'd224, 8'd216}, {8'd181, 8'd63, 8'd227, 8'd205},
                32'd95128, 1'b0, 32'd32250, 1'b0, "l2");

    // LEN=2 with out_ready low: first result held, 2nd group's closing pair stalls
    ordy[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = (i == 0) ? 8'd216 : (i == 1) ? 8'd224 : (i == 2) ? 8'd12 : 8'd174;
      b = (i == 0) ? 8'd205 : (i == 1) ? 8'd227 : (i == 2) ? 8'd63 : 8'd181;
      vld[1] = 1'b1;
      #1;
      check($sformatf("bp_ready%0d", i), 32'(rdy[1]), 32'd1);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      a = 8'd1; b = 8'd1; vld[1] = 1'b1;
      #1;
      check($sformatf("bp_stall%0d", j), 32'(rdy[1]), 32'd0);
      check($sformatf("bp_hold_v%0d", j), 32'(ov[1]), 32'd1);
      check($sformatf("bp_hold_s%0d", j), os[1], 32'd95128);
    end
    @(negedge clk);
    ordy[1] = 1'b1;
    #1;
    check("bp_release_ready", 32'(rdy[1]), 32'd1);
    check("bp_first_sum", os[1], 32'd95128);
    @(negedge clk);
    check("bp_second_valid", 32'(ov[1]), 32'd1);
    check("bp_second_sum", os[1], 32'd32250);
    a = 8'd2; b = 8'd2; vld[1] = 1'b1;
    #1;
    check("bp_g3_ready", 32'(rdy[1]), 32'd1);
    @(negedge clk);
    check("bp_no_dup", 32'(ov[1]), 32'd0);
    vld[1] = 1'b0;
    @(negedge clk);
    check("bp_third_valid", 32'(ov[1]), 32'd1);
    check("bp_third_sum", os[1], 32'd5);
    @(negedge clk);
    check("bp_third_retired", 32'(ov[1]), 32'd0);

    // LEN=4: two (10,10), clear (with a pair offered), then four (1,2) -> 8
    ordy[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = 8'd10; b = 8'd10; vld[2] = 1'b1;
    end
    @(negedge clk);
    a = 8'd100; b = 8'd100; clear = 1'b1;
    #1;
    check("clr_ready", 32'(rdy[2]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear = 1'b0; a = 8'd1; b = 8'd2; vld[2] = 1'b1;
      #1;
      check($sformatf("clr_ready%0d", i), 32'(rdy[2]), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld[2] = 1'b0;
      check($sformatf("clr_valid%0d", i), 32'(ov[2]), 32'(i == 1));
      if (i == 1) begin
        check("clr_sum", os[2], 32'd8);
        check("clr_ovf", 32'(of[2]), 32'd0);
      end
    end

    // LEN=2, ACC_W=16: wrap with overflow, then a clean group
    len2_stream(3, {8'd1, 8'd1, 8'd255, 8'd255}, {8'd1, 8'd1, 8'd255, 8'd255},
                32'd64514, 1'b1, 32'd2, 1'b0, "w16");

    // Async reset mid-group with a pending result on LEN=8
    ordy[0] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a = 8'd2; b = 8'd3; vld[0] = 1'b1;
      #1;
      check($sformatf("ar_ready%0d", i), 32'(rdy[0]), 32'd1);
    end
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    check("ar_pending_valid", 32'(ov[0]), 32'd1);
    check("ar_pending_sum", os[0], 32'd48);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(ov[0]), 32'd0);
    check("ar_sum", os[0], 32'd0);
    check("ar_ovf", 32'(of[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = 8'd3; b = 8'd3; vld[0] = 1'b1;
    end
    @(negedge clk);
    vld[0] = 1'b0;
    t = 0;
    while (!ov[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("post_rst_valid", 32'(ov[0]), 32'd1);
    check("post_rst_sum", os[0], 32'd72);
    check("post_rst_ovf", 32'(of[0]), 32'd0);

    // Random stream on the LEN=2/16-bit instance against a scoreboard model
    macc = 0; mcnt = 0; movf = 1'b0; n_acc = 0; cyc = 0; dcnt = 0;
    while (cyc < 40000) begin
      @(negedge clk);
      if (n_acc >= 10000) begin
        vld[3] = 1'b0;
        ordy[3] = 1'b1;
      end else begin
        vld[3] = ($urandom_range(0, 3) != 0);
        ordy[3] = ($urandom_range(0, 2) != 0);
      end
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      #1;
      if (ov[3] && ordy[3]) begin
        check("rnd_expected_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rnd_sum", os[3], 32'(e[15:0]));
          check("rnd_ovf", 32'(of[3]), 32'(e[16]));
        end
      end
      if (vld[3] && rdy[3]) begin
        n_acc++;
        p = 32'(a) * 32'(b);
        s = macc + p;
        carry = (s >= 32'd65536);
        s = s & 32'hFFFF;
        if (mcnt == 1) begin
          q.push_back({movf | carry, s[15:0]});
          macc = 0; movf = 1'b0; mcnt = 0;
        end else begin
          macc = s; movf = movf | carry; mcnt = 1;
        end
      end
      cyc++;
      if (n_acc >= 10000) begin
        dcnt++;
        if (dcnt == 10) break;
      end
    end
    check("rnd_accepted", 32'(n_acc), 32'd10000);
    check("rnd_drained", 32'(q.size()), 32'd0);
    check("rnd_idle", 32'(ov[3]), 32'd0);
    vld[3] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
